// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI slave, synchronized inputs, CPU tx buffer and rx status word
// Optional feature: define SPI_SLAVE_OVERRUN_EN to add the overrun flag in out[13].
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] in,
    input  logic        read,
    output logic [15:0] out,
    input  logic        CSX,
    input  logic        SCK,
    input  logic        SDI,
    output logic        SDO
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] csx_sync, sck_sync, sdi_sync;
    logic                   csx_s, sck_s, sdi_s, sck_prev;
    logic                   start, stop, sck_rise, sck_fall, byte_done;
    logic [2:0]             bit_cnt;
    logic [7:0]             tx_buf, tx_shift, rx_shift, rx_data;
    logic                   rx_valid, ov_bit;
    logic                   unused_in;

    assign csx_s     = csx_sync[SYNC_STAGES-1];
    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign unused_in = ^in[15:8];

    // Bring the asynchronous SPI pins into the clk domain; CSX idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csx_sync <= '1;
            sck_sync <= '0;
            sdi_sync <= '0;
            sck_prev <= 1'b0;
        end else begin
            csx_sync <= {csx_sync[SYNC_STAGES-2:0], CSX};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCK};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], SDI};
            sck_prev <= sck_s;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state follows synced CSX; SCK edges only count while selected
    always_comb begin
        state_nxt = csx_s ? IDLE : ACTIVE;
        start     = (state == IDLE) && !csx_s;
        stop      = (state == ACTIVE) && csx_s;
        sck_rise  = (state == ACTIVE) && !csx_s && sck_s && !sck_prev;
        sck_fall  = (state == ACTIVE) && !csx_s && !sck_s && sck_prev;
        byte_done = sck_rise && (bit_cnt == 3'd7);
    end

    // Shift registers, bit counter, tx buffer and received byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= 3'd0;
            tx_buf   <= 8'h00;
            tx_shift <= 8'h00;
            rx_shift <= 8'h00;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            if (start) begin
                bit_cnt  <= 3'd0;
                tx_shift <= tx_buf;
                rx_shift <= 8'h00;
            end else if (stop) begin
                bit_cnt  <= 3'd0;
                rx_shift <= 8'h00;
            end else begin
                if (sck_rise) begin
                    rx_shift <= {rx_shift[6:0], sdi_s};
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (sck_fall) tx_shift <= (bit_cnt == 3'd0) ? tx_buf : {tx_shift[6:0], 1'b0};
            end
            if (byte_done) rx_data <= {rx_shift[6:0], sdi_s};
            if (load) tx_buf <= in[7:0];
            rx_valid <= byte_done | (rx_valid & ~read);
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic overrun;

    // Flag a byte that lands on top of an unacknowledged one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun <= 1'b0;
        else        overrun <= (byte_done & rx_valid & ~read) | (overrun & ~read);
    end

    assign ov_bit = overrun;
`else
    assign ov_bit = 1'b0;
`endif

    assign out = {state == ACTIVE, rx_valid, ov_bit, 5'd0, rx_data};
    assign SDO = (state == ACTIVE) & tx_shift[7];
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed checks of spi_slave with a bit-banged mode-0 master
module tb_spi_slave;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] in = 16'h0000;
    logic        read = 1'b0;
    logic [15:0] out;
    logic        CSX = 1'b1;
    logic        SCK = 1'b0;
    logic        SDI = 1'b0;
    logic        SDO;
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  miso;

`ifdef SPI_SLAVE_OVERRUN_EN
    localparam logic [15:0] EXP_TWO_BYTES = 16'h6002;
    localparam logic [15:0] EXP_B2B       = 16'h6022;
`else
    localparam logic [15:0] EXP_TWO_BYTES = 16'h4002;
    localparam logic [15:0] EXP_B2B       = 16'h4022;
`endif

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .in(in), .read(read), .out(out),
        .CSX(CSX), .SCK(SCK), .SDI(SDI), .SDO(SDO)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_load(input logic [15:0] v);
        in = v;
        load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    task automatic cpu_read();
        read = 1'b1;
        tick(1);
        read = 1'b0;
    endtask

    task automatic spi_bits(input logic [7:0] mosi, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            SDI = mosi[i];
            tick(4);
            rx[i] = SDO;
            SCK = 1'b1;
            tick(4);
            SCK = 1'b0;
        end
        tick(4);
    endtask

    task automatic cs_low();
        CSX = 1'b0;
        tick(6);
    endtask

    task automatic cs_high();
        CSX = 1'b1;
        tick(4);
    endtask

    initial begin
        tick(3);
        check("reset_out", out, 16'h0000);
        check("reset_sdo", {15'd0, SDO}, 16'h0000);
        rst_n = 1'b1;
        tick(2);

        cpu_load(16'h00A5);
        cs_low();
        check("busy_active", {15'd0, out[15]}, 16'h0001);
        spi_bits(8'h3C, 8, miso);
        check("tx_a5", {8'd0, miso}, 16'h00A5);
        cs_high();
        check("rx_3c", out, 16'h403C);
        cpu_read();
        check("read_clr", out, 16'h003C);

        cpu_load(16'h005A);
        cs_low();
        spi_bits(8'h11, 8, miso);
        check("b2b_tx0", {8'd0, miso}, 16'h005A);
        spi_bits(8'h22, 8, miso);
        check("b2b_tx1", {8'd0, miso}, 16'h005A);
        cs_high();
        check("b2b_rx", out, EXP_B2B);
        cpu_read();

        cs_low();
        spi_bits(8'hFF, 5, miso);
        check("partial_busy", {15'd0, out[15]}, 16'h0001);
        CSX = 1'b1;
        tick(3);
        check("partial_abort", out, 16'h0022);
        tick(2);
        cs_low();
        spi_bits(8'h3C, 8, miso);
        cs_high();
        check("after_abort", out, 16'h403C);
        cpu_read();

        cs_low();
        spi_bits(8'h01, 8, miso);
        cs_high();
        cs_low();
        spi_bits(8'h02, 8, miso);
        cs_high();
        check("two_bytes", out, EXP_TWO_BYTES);
        cpu_read();
        check("two_bytes_read", out, 16'h0002);

        cs_low();
        spi_bits(8'h77, 7, miso);
        SDI = 1'b1;
        tick(4);
        SCK = 1'b1;
        tick(2);
        check("valid_latency", {15'd0, out[14]}, 16'h0000);
        read = 1'b1;
        tick(1);
        read = 1'b0;
        check("valid_set", {15'd0, out[14]}, 16'h0001);
        tick(1);
        SCK = 1'b0;
        tick(4);
        cs_high();
        check("read_collide", out, 16'h4077);
        cpu_read();

        cpu_load(16'h00C3);
        cs_low();
        spi_bits(8'h00, 8, miso);
        check("mid_tx0", {8'd0, miso}, 16'h00C3);
        cpu_load(16'hFF0F);
        spi_bits(8'h00, 8, miso);
        check("mid_tx1", {8'd0, miso}, 16'h00C3);
        spi_bits(8'h00, 8, miso);
        check("mid_tx2", {8'd0, miso}, 16'h000F);
        spi_bits(8'h00, 8, miso);
        check("repeat_tx", {8'd0, miso}, 16'h000F);
        cs_high();
        cpu_read();

        cpu_load(16'h00FF);
        cs_low();
        spi_bits(8'h00, 3, miso);
        SCK = 1'b1;
        tick(2);
        check("pre_rst_sdo", {15'd0, SDO}, 16'h0001);
        rst_n = 1'b0;
        #1;
        check("rst_out", out, 16'h0000);
        check("rst_sdo", {15'd0, SDO}, 16'h0000);
        SCK = 1'b0;
        CSX = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        cs_low();
        spi_bits(8'h99, 8, miso);
        check("post_rst_tx", {8'd0, miso}, 16'h0000);
        cs_high();
        check("post_rst_rx", out, 16'h4099);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on each SPI input (legal 2..3).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port load, input, 1 bit: writes in[7:0] to the transmit buffer; in[15:8] ignored.
REQ-005 SHALL have port in, input, 16 bits: CPU write data.
REQ-006 SHALL have port read, input, 1 bit: CPU acknowledge; clears rx_valid and overrun.
REQ-007 SHALL have port out, output, 16 bits: {busy, rx_valid, overrun, 5'd0, rx_data[7:0]}.
REQ-008 SHALL have port CSX, input, 1 bit: chip select from master, active low.
REQ-009 SHALL have port SCK, input, 1 bit: serial clock from master, mode 0 (CPOL=0, CPHA=0).
REQ-010 SHALL have port SDI, input, 1 bit: serial data from master, MSB first.
REQ-011 SHALL have port SDO, output, 1 bit: serial data to master, MSB first.

Function
REQ-012 SHALL pass CSX, SCK and SDI through SYNC_STAGES flops; all protocol decisions use synchronized values only.
REQ-013 SHALL detect SCK edges by comparing synchronized SCK with its previous registered value; an edge is acted on at the next clk edge.
REQ-014 SHALL implement two states: IDLE (synced CSX high) and ACTIVE (synced CSX low).
REQ-015 IDLE->ACTIVE on synced CSX falling: bit counter=0, tx shift register loaded from tx buffer.
REQ-016 ACTIVE->IDLE on synced CSX rising, including mid-byte: bit counter=0, partial receive discarded, rx_valid/rx_data unchanged.
REQ-017 SDO SHALL equal tx shift[7] in ACTIVE and 0 in IDLE.
REQ-018 On each SCK rising in ACTIVE: synced SDI shifted into the receive register LSB, bit counter incremented.
REQ-019 On each SCK falling in ACTIVE: tx shift shifts left by one, except after the 8th rising edge, when it reloads from the tx buffer (back-to-back bytes).
REQ-020 On the 8th SCK rising: rx_data={rx_shift[6:0],SDI_sync}, rx_valid=1, bit counter wraps to 0.
REQ-021 rx_valid SHALL become visible SYNC_STAGES clk edges after the first clk edge that samples the 8th SCK pin high.
REQ-022 load in ACTIVE SHALL update the tx buffer only; the byte in flight is unaffected, the new value is used at the next byte boundary.
REQ-023 The tx buffer SHALL retain its value after transmission (repeated bytes resend it).
REQ-024 read SHALL clear rx_valid and overrun; read coinciding with byte completion leaves rx_valid=1, overrun=0.
REQ-025 busy (out[15]) SHALL equal the ACTIVE state.
REQ-026 Correct operation SHALL require SCK high and low phases each >= SYNC_STAGES+1 clk periods.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, bit counter 0, tx buffer 0x00, tx/rx shift 0x00, rx_data 0x00, rx_valid 0, overrun 0, synchronizers to CSX=1/SCK=0/SDI=0, so out=0x0000 and SDO=0.
REQ-028 Reset mid-transfer SHALL abort; after release the block waits for a fresh CSX falling edge.

Configuration
REQ-029 With SPI_SLAVE_OVERRUN_EN defined: byte completion while rx_valid=1 and read=0 sets overrun=1 and overwrites rx_data.
REQ-030 Without SPI_SLAVE_OVERRUN_EN: out[13] is constant 0, no overrun flop exists, new bytes overwrite rx_data silently.

Verification
REQ-031 load in=0x00A5, master sends 0x3C (SCK half-period 4 clk) -> master receives 0xA5 on SDO; out=0x403C after completion.
REQ-032 Two back-to-back bytes 0x11,0x22 in one CSX low window, tx buffer 0x5A -> master receives 0x5A,0x5A; rx_data=0x22.
REQ-033 CSX deasserted after 5 SCK pulses -> rx_valid stays 0, rx_data unchanged, busy=0 within SYNC_STAGES+1 clk.
REQ-034 Two bytes 0x01,0x02 without read (OVERRUN_EN defined) -> out=0x6002; pulse read -> out=0x0002; undefined -> out=0x4002.
REQ-035 read asserted on the rx_valid-set cycle of a new byte 0x77 -> out=0x4077 (rx_valid held, no overrun).
REQ-036 rst_n pulsed low during bit 4 -> out=0x0000, SDO=0 immediately; next full byte 0x99 -> rx_data=0x99.
